bishift_frame_feeder: RTL and testbench

Upstream feeder for the bidirectional shift register stage. Accepts one parallel word per valid/ready handshake together with a direction bit, then drives the shift register's serial data, enable and direction inputs for exactly MSB consecutive cycles. After those MSB shifts, the downstream register's parallel output equals the accepted word. A one-cycle completion pulse and a programmable idle gap close each frame.

---
 rtl/bishift_frame_feeder.sv | 137 +++++++++++++
 tb/tb_bishift_frame_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bishift_frame_feeder.sv
// ============================================================================
// Module   : bishift_frame_feeder
// Purpose  : Serialises one accepted parallel word into a bidirectional shift
//            register stage over MSB cycles, then closes the frame with a
//            completion pulse and a programmable idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bishift_frame_feeder #(
    parameter int MSB = 4,
    parameter int GAP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MSB-1:0] in_data,
    input  logic           in_dir,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           sh_d,
    output logic           sh_en,
    output logic           sh_dir,
    output logic           busy,
    output logic           frame_done
);

    localparam int              c_CW       = $clog2(MSB);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MSB - 1);
    localparam logic [3:0]      c_GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_gcnt;
    logic [MSB-1:0]  r_word;
    logic            r_in_ready;
    logic            r_sh_d;
    logic            r_sh_en;
    logic            r_sh_dir;
    logic            r_busy;
    logic            r_frame_done;

    // r_word holds the bits not yet sent, pre-shifted so the next bit always
    // sits at the end matching the direction (MSB end for left, LSB end for right).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_gcnt       <= '0;
            r_word       <= '0;
            r_in_ready   <= 1'b0;
            r_sh_d       <= 1'b0;
            r_sh_en      <= 1'b0;
            r_sh_dir     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_state    <= c_ST_SHIFT;
                        r_busy     <= 1'b1;
                        r_sh_en    <= 1'b1;
                        r_sh_dir   <= in_dir;
                        r_cnt      <= '0;
                        if (in_dir) begin
                            r_sh_d <= in_data[0];
                            r_word <= in_data >> 1;
                        end else begin
                            r_sh_d <= in_data[MSB-1];
                            r_word <= in_data << 1;
                        end
                    end
                end

                c_ST_SHIFT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_sh_en      <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_cnt        <= '0;
                        if (GAP == 0) begin
                            r_state    <= c_ST_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= c_ST_GAP;
                            r_gcnt  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_sh_dir) begin
                            r_sh_d <= r_word[0];
                            r_word <= r_word >> 1;
                        end else begin
                            r_sh_d <= r_word[MSB-1];
                            r_word <= r_word << 1;
                        end
                    end
                end

                c_ST_GAP: begin
                    if (r_gcnt == c_GAP_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_gcnt     <= '0;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= c_ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_sh_en    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign sh_d       = r_sh_d;
    assign sh_en      = r_sh_en;
    assign sh_dir     = r_sh_dir;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_bishift_frame_feeder.sv
// ============================================================================
// Module   : tb_bishift_frame_feeder
// Purpose  : Scoreboard bench for bishift_frame_feeder, one instance with
//            GAP=0 and one with GAP=2, each driving a downstream shift model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bishift_frame_feeder;

    typedef struct packed {
        logic [3:0] word;
        logic [3:0] seq;
        logic       dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0] din0 = '0, din2 = '0;
    logic       dir0 = 1'b0, dir2 = 1'b0, valid0 = 1'b0, valid2 = 1'b0;
    logic       w_ready0, w_shd0, w_shen0, w_shdir0, w_busy0, w_done0;
    logic       w_ready2, w_shd2, w_shen2, w_shdir2, w_busy2, w_done2;
    logic [3:0] ds0, ds2;

    exp_t q0[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0] col0, col2;
    int         n0, n2;
    logic       fd0, fd2, dbad0, dbad2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bishift_frame_feeder #(.MSB(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(din0), .in_dir(dir0), .in_valid(valid0),
        .in_ready(w_ready0), .sh_d(w_shd0), .sh_en(w_shen0), .sh_dir(w_shdir0),
        .busy(w_busy0), .frame_done(w_done0)
    );

    bishift_frame_feeder #(.MSB(4), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(din2), .in_dir(dir2), .in_valid(valid2),
        .in_ready(w_ready2), .sh_d(w_shd2), .sh_en(w_shen2), .sh_dir(w_shdir2),
        .busy(w_busy2), .frame_done(w_done2)
    );

    // Downstream bidirectional shift registers: dir 0 enters at LSB, dir 1 at MSB.
    always @(posedge clk or posedge rst) begin
        if (rst) ds0 <= '0;
        else if (w_shen0) ds0 <= w_shdir0 ? {w_shd0, ds0[3:1]} : {ds0[2:0], w_shd0};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) ds2 <= '0;
        else if (w_shen2) ds2 <= w_shdir2 ? {w_shd2, ds2[3:1]} : {ds2[2:0], w_shd2};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n0 <= 0; dbad0 <= 1'b0; col0 <= '0;
        end else begin
            if (w_shen0) begin
                col0 <= {col0[2:0], w_shd0};
                n0   <= n0 + 1;
                if (n0 == 0) fd0 <= w_shdir0;
                else if (w_shdir0 !== fd0) dbad0 <= 1'b1;
            end
            if (w_done0) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_done", 1, 0);
                end else begin
                    check("dut0_sh_d_sequence", col0, q0[0].seq);
                    check("dut0_downstream_out", ds0, q0[0].word);
                    check("dut0_sh_en_cycles", n0, 4);
                    check("dut0_sh_dir", {dbad0, fd0}, {1'b0, q0[0].dir});
                    void'(q0.pop_front());
                end
                n0 <= 0; dbad0 <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            n2 <= 0; dbad2 <= 1'b0; col2 <= '0;
        end else begin
            if (w_shen2) begin
                col2 <= {col2[2:0], w_shd2};
                n2   <= n2 + 1;
                if (n2 == 0) fd2 <= w_shdir2;
                else if (w_shdir2 !== fd2) dbad2 <= 1'b1;
            end
            if (w_done2) begin
                if (q2.size() == 0) begin
                    check("dut2_unexpected_done", 1, 0);
                end else begin
                    check("dut2_sh_d_sequence", col2, q2[0].seq);
                    check("dut2_downstream_out", ds2, q2[0].word);
                    check("dut2_sh_en_cycles", n2, 4);
                    check("dut2_sh_dir", {dbad2, fd2}, {1'b0, q2[0].dir});
                    void'(q2.pop_front());
                end
                n2 <= 0; dbad2 <= 1'b0;
            end
        end
    end

    task automatic wait_ready(input int which);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (which == 0) ? w_ready0 : w_ready2;
        end
        if (!ok) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int which);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (which == 0) ? (q0.size() == 0 && w_ready0) : (q2.size() == 0 && w_ready2);
        end
        if (!ok) check("wait_drain_timeout", 0, 1);
    endtask

    task automatic send(input int which, input logic [3:0] w, input logic d, input logic [3:0] seq);
        wait_ready(which);
        if (which == 0) begin
            din0 = w; dir0 = d; valid0 = 1'b1; q0.push_back(exp_t'{w, seq, d});
        end else begin
            din2 = w; dir2 = d; valid2 = 1'b1; q2.push_back(exp_t'{w, seq, d});
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic wait_done(input int which, output int at);
        logic ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (which == 0) ? w_done0 : w_done2;
        end
        if (ok) at = cyc;
        else check("wait_done_timeout", 0, 1);
    endtask

    int t1, t2, ta, tr;

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_async_dut0", {w_ready0, w_shd0, w_shen0, w_shdir0, w_busy0, w_done0}, 0);
        check("rst_async_dut2", {w_ready2, w_shd2, w_shen2, w_shdir2, w_busy2, w_done2}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("ready_low_before_edge", w_ready0, 0);
        @(posedge clk);
        #1;
        check("ready_after_rst_dut0", w_ready0, 1);
        check("ready_after_rst_dut2", w_ready2, 1);

        // Left frame: 1011 sent MSB-first -> 1,0,1,1.
        send(0, 4'b1011, 1'b0, 4'b1011);
        wait_drain(0);

        // Right frame: 1011 sent LSB-first -> 1,1,0,1.
        send(0, 4'b1011, 1'b1, 4'b1101);
        wait_drain(0);

        // Back-to-back, GAP=0, valid held high throughout.
        wait_ready(0);
        din0 = 4'hA; dir0 = 1'b0; valid0 = 1'b1;
        q0.push_back(exp_t'{4'hA, 4'b1010, 1'b0});
        @(posedge clk);
        #1;
        din0 = 4'h5; dir0 = 1'b1;
        q0.push_back(exp_t'{4'h5, 4'b1010, 1'b1});
        wait_done(0, t1);
        check("b2b_single_idle_cycle", w_shen0, 0);
        check("b2b_ready_with_done", w_ready0, 1);
        @(negedge clk);
        check("b2b_second_frame_starts", w_shen0, 1);
        valid0 = 1'b0;
        wait_done(0, t2);
        check("b2b_done_spacing", t2 - t1, 5);
        wait_drain(0);

        // GAP=2: pulses of in_valid during SHIFT and GAP must be ignored.
        send(2, 4'b0110, 1'b0, 4'b0110);
        ta = cyc;
        @(negedge clk);
        @(negedge clk);
        din2 = 4'b1111; dir2 = 1'b1; valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
        wait_done(2, t1);
        @(posedge clk);
        #1;
        check("gap_busy", w_busy2, 1);
        check("gap_not_ready", w_ready2, 0);
        din2 = 4'b1111; dir2 = 1'b1; valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
        wait_ready(2);
        tr = cyc;
        // First ready cycle is accept+7; its negedge follows accept edge + 6 edges.
        check("gap_ready_latency", tr - ta, 6);
        repeat (6) @(negedge clk);
        check("gap_no_extra_accept", {w_busy2, w_shen2}, 0);
        check("gap_queue_empty", q2.size(), 0);
        check("gap_downstream_kept", ds2, 4'b0110);

        // Reset mid-frame after two shifts.
        wait_ready(0);
        din0 = 4'b1001; dir0 = 1'b0; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_outputs", {w_ready0, w_shd0, w_shen0, w_shdir0, w_busy0, w_done0}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        send(0, 4'b1100, 1'b1, 4'b0011);
        wait_drain(0);
        check("final_queue0_empty", q0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
